// File: rtl/sterownik_ustawienia.sv
// rtl/sterownik_ustawienia.sv - two-port round-robin arbiter and sequencer for the bit-set unit

// Bit-set datapath: set bit B of the mask and combine with inverted A.
// Any B that is negative or outside 0..BITS-1 flags an error and yields zero.
module sterownik_ustawienia_bitset #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] arg_a_i,
  input  logic [BITS-1:0] arg_b_i,
  output logic [BITS-1:0] result_o,
  output logic            error_o
);

  localparam int IDX_W = $clog2(BITS);

  logic [IDX_W-1:0] idx;
  logic             out_of_range;
  logic [BITS-1:0]  one_hot;

  // Range check on the sign bit and the bits above the index field, then build the result.
  always_comb begin
    idx          = arg_b_i[IDX_W-1:0];
    out_of_range = arg_b_i[BITS-1] | (|arg_b_i[BITS-2:IDX_W]);
    one_hot      = {{(BITS-1){1'b0}}, 1'b1} << idx;
    error_o      = out_of_range;
    result_o     = '0;
    if (!out_of_range) begin
      result_o = one_hot | ~arg_a_i;
    end
  end

endmodule

// Arbiter/sequencer: IDLE grants one requester, LICZ computes and registers the
// result, WYNIK holds it until the downstream consumer takes it.
module sterownik_ustawienia #(
  parameter int BITS  = 32,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  input  logic [BITS-1:0]  i_req0_arg_A,
  input  logic [BITS-1:0]  i_req0_arg_B,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [BITS-1:0]  i_req1_arg_A,
  input  logic [BITS-1:0]  i_req1_arg_B,
  output logic             o_req1_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [BITS-1:0]  o_result,
  output logic             o_error,
  output logic             o_grant_id,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LICZ  = 2'd1,
    WYNIK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [BITS-1:0]  a_q, a_d;
  logic [BITS-1:0]  b_q, b_d;
  logic             gid_q, gid_d;
  logic [BITS-1:0]  result_q, result_d;
  logic             error_q, error_d;
  logic             grant_id_q, grant_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             grant0, grant1;
  logic [BITS-1:0]  bs_result;
  logic             bs_error;

  sterownik_ustawienia_bitset #(
    .BITS (BITS)
  ) u_bitset (
    .arg_a_i  (a_q),
    .arg_b_i  (b_q),
    .result_o (bs_result),
    .error_o  (bs_error)
  );

  // Next-state, arbitration and register-load decisions; every target defaults to hold.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    gid_d      = gid_q;
    result_d   = result_q;
    error_d    = error_q;
    grant_id_d = grant_id_q;
    cnt_d      = cnt_q;
    grant0     = 1'b0;
    grant1     = 1'b0;

    case (state_q)
      IDLE: begin
        // Contention goes to the pointer's requester; a lone request always wins.
        if (i_req0_valid && i_req1_valid) begin
          grant0 = ~ptr_q;
          grant1 = ptr_q;
        end else begin
          grant0 = i_req0_valid;
          grant1 = i_req1_valid;
        end
        if (grant0 || grant1) begin
          gid_d   = grant1;
          a_d     = grant1 ? i_req1_arg_A : i_req0_arg_A;
          b_d     = grant1 ? i_req1_arg_B : i_req0_arg_B;
          ptr_d   = ~grant1;
          state_d = LICZ;
        end
      end
      LICZ: begin
        result_d   = bs_result;
        error_d    = bs_error;
        grant_id_d = gid_q;
        state_d    = WYNIK;
      end
      WYNIK: begin
        if (i_ready) begin
          if (error_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      gid_q      <= 1'b0;
      result_q   <= '0;
      error_q    <= 1'b0;
      grant_id_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      gid_q      <= gid_d;
      result_q   <= result_d;
      error_q    <= error_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
    end
  end

  // Readies are combinational but forced low while reset is held.
  assign o_req0_ready = grant0 & i_rst_n;
  assign o_req1_ready = grant1 & i_rst_n;
  assign o_valid      = (state_q == WYNIK);
  assign o_busy       = (state_q != IDLE);
  assign o_result     = result_q;
  assign o_error      = error_q;
  assign o_grant_id   = grant_id_q;
  assign o_err_count  = cnt_q;

endmodule

// File: tb/tb_sterownik_ustawienia.sv
// tb/tb_sterownik_ustawienia.sv - scoreboard bench for sterownik_ustawienia
module tb_sterownik_ustawienia;

  localparam int BITS  = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_req0_valid, i_req1_valid;
  logic [BITS-1:0]  i_req0_arg_A, i_req0_arg_B, i_req1_arg_A, i_req1_arg_B;
  logic             o_req0_ready, o_req1_ready;
  logic             o_valid, i_ready, o_error, o_grant_id, o_busy;
  logic [BITS-1:0]  o_result;
  logic [CNT_W-1:0] o_err_count;

  sterownik_ustawienia #(.BITS(BITS), .CNT_W(CNT_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (i_req0_valid),
    .i_req0_arg_A (i_req0_arg_A),
    .i_req0_arg_B (i_req0_arg_B),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (i_req1_valid),
    .i_req1_arg_A (i_req1_arg_A),
    .i_req1_arg_B (i_req1_arg_B),
    .o_req1_ready (o_req1_ready),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result),
    .o_error      (o_error),
    .o_grant_id   (o_grant_id),
    .o_busy       (o_busy),
    .o_err_count  (o_err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
    logic        gid;
  } exp_t;

  exp_t             exp_q[$];
  int               glog[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               st_m;
  logic             ptr_m;
  logic [CNT_W-1:0] cnt_m;
  logic             e0, e1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic gid);
    exp_t e;
    e.gid = gid;
    if ($signed(b) < 0 || $signed(b) > 31) begin
      e.err = 1'b1;
      e.res = 32'h0;
    end else begin
      e.err = 1'b0;
      e.res = (32'd1 << b) | ~a;
    end
    return e;
  endfunction

  // Monitor: reference FSM/arbiter model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st_m  = 0;
        ptr_m = 1'b0;
        cnt_m = '0;
        exp_q.delete();
      end else begin
        e0 = 1'b0;
        e1 = 1'b0;
        if (st_m == 0) begin
          if (i_req0_valid && i_req1_valid) begin
            e0 = ~ptr_m;
            e1 = ptr_m;
          end else begin
            e0 = i_req0_valid;
            e1 = i_req1_valid;
          end
        end
        check("rdy0", {31'b0, o_req0_ready}, {31'b0, e0});
        check("rdy1", {31'b0, o_req1_ready}, {31'b0, e1});
        check("rdy_excl", {31'b0, o_req0_ready & o_req1_ready}, 32'd0);
        check("valid", {31'b0, o_valid}, {31'b0, st_m == 2});
        check("busy", {31'b0, o_busy}, {31'b0, st_m != 0});
        check("errcnt", {30'b0, o_err_count}, {30'b0, cnt_m});
        if (st_m == 2 && exp_q.size() > 0) begin
          check("result", o_result, exp_q[0].res);
          check("error", {31'b0, o_error}, {31'b0, exp_q[0].err});
          check("gid", {31'b0, o_grant_id}, {31'b0, exp_q[0].gid});
        end
        if (e0 || e1) begin
          if (e1) exp_q.push_back(model(i_req1_arg_A, i_req1_arg_B, 1'b1));
          else    exp_q.push_back(model(i_req0_arg_A, i_req0_arg_B, 1'b0));
          glog.push_back(e1 ? 1 : 0);
          ptr_m = ~e1;
          st_m  = 1;
        end else if (st_m == 1) begin
          st_m = 2;
        end else if (st_m == 2 && i_ready) begin
          if (exp_q.size() > 0) begin
            if (exp_q[0].err && cnt_m != {CNT_W{1'b1}}) cnt_m = cnt_m + 1'b1;
            void'(exp_q.pop_front());
          end
          st_m = 0;
        end
      end
    end
  end

  task automatic wait_grants(input int n);
    int start;
    int k;
    start = glog.size();
    k = 0;
    while (glog.size() < start + n && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("grant_wait", glog.size(), start + n);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(st_m == 0 && exp_q.size() == 0) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle_wait", {31'b0, (st_m == 0 && exp_q.size() == 0)}, 32'd1);
  endtask

  task automatic send(input int id, input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin
      i_req0_arg_A = a; i_req0_arg_B = b; i_req0_valid = 1'b1;
    end else begin
      i_req1_arg_A = a; i_req1_arg_B = b; i_req1_valid = 1'b1;
    end
    wait_grants(1);
    if (id == 0) i_req0_valid = 1'b0;
    else         i_req1_valid = 1'b0;
  endtask

  initial begin
    int s;
    rst_n = 1'b0;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    i_req0_arg_A = '0; i_req0_arg_B = '0; i_req1_arg_A = '0; i_req1_arg_B = '0;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_errcnt", {30'b0, o_err_count}, 32'd0);
    rst_n = 1'b1;

    // Single request from requester 0.
    send(0, 32'hFFFF_FFFF, 32'd5);
    wait_idle();
    check("t1_gid_log", glog[glog.size()-1], 0);

    // Asynchronous reset while an error result is held.
    i_ready = 1'b0;
    send(0, 32'h0, 32'd32);
    @(posedge clk); #1;
    i_req0_arg_A = '0; i_req0_arg_B = 32'd0;
    i_req1_arg_A = '0; i_req1_arg_B = 32'd31;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, o_valid}, 32'd0);
    check("arst_result", o_result, 32'd0);
    check("arst_error", {31'b0, o_error}, 32'd0);
    check("arst_gid", {31'b0, o_grant_id}, 32'd0);
    check("arst_busy", {31'b0, o_busy}, 32'd0);
    check("arst_errcnt", {30'b0, o_err_count}, 32'd0);
    check("arst_rdy0", {31'b0, o_req0_ready}, 32'd0);
    check("arst_rdy1", {31'b0, o_req1_ready}, 32'd0);
    i_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both valid continuously: grants alternate starting at requester 0.
    s = glog.size();
    wait_grants(4);
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) check("alt_gid", glog[s+k], k % 2);
    wait_idle();

    // Requester 1 alone, then both valid: requester 0 wins.
    send(1, 32'h0, 32'd31);
    wait_idle();
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    wait_grants(1);
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    check("rr_after_r1", glog[glog.size()-1], 0);
    wait_idle();

    // Backpressure: result held, competing request waits.
    i_ready = 1'b0;
    send(1, 32'h1234_5678, 32'd7);
    i_req0_arg_A = 32'hFFFF_FFFF; i_req0_arg_B = 32'd0; i_req0_valid = 1'b1;
    s = glog.size();
    repeat (11) begin
      @(posedge clk); #1;
    end
    check("bp_no_grant", glog.size(), s);
    i_ready = 1'b1;
    wait_grants(1);
    i_req0_valid = 1'b0;
    check("bp_next_gid", glog[glog.size()-1], 0);
    wait_idle();

    // Error boundaries and counter saturation.
    send(0, 32'h0, 32'd32);          wait_idle();
    send(0, 32'h0, 32'hFFFF_FFFF);   wait_idle();
    send(0, 32'h0, 32'h7FFF_FFFF);   wait_idle();
    send(1, 32'hFFFF_FFFF, 32'd31);  wait_idle();
    send(0, 32'h5, 32'd32);          wait_idle();
    send(1, 32'h5, 32'd40);          wait_idle();
    check("sat_final", {30'b0, o_err_count}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sterownik_ustawienia.md
# sterownik_ustawienia

Two-port round-robin arbiter and sequencer for the shared bit-set datapath (set bit B of the mask, combine with inverted A) of the synchronous arithmetic unit. It accepts operand pairs from two requesters and serialises them onto one bit-set unit instance. It registers result and error flag and presents them downstream under a valid/ready handshake. It also tracks which requester each result belongs to and keeps a saturating error count.

## Interface
Parameters:
- BITS, 32, operand/result width; must be a power of two ≥ 4
- CNT_W, 8, width of error counter

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  reset; asynchronous, active-low
- i_req0_valid  input  1  requester 0 has operands
- i_req0_arg_A  input  BITS  requester 0 operand A (signed)
- i_req0_arg_B  input  BITS  requester 0 bit index B (signed)
- o_req0_ready  output  1  requester 0 operands accepted this cycle when high with valid
- i_req1_valid, i_req1_arg_A, i_req1_arg_B, o_req1_ready  same as requester 0, for requester 1
- o_valid  output  1  result register holds a completed operation
- i_ready  input  1  downstream accepts result
- o_result  output  BITS  registered result
- o_error  output  1  registered error flag for the held result
- o_grant_id  output  1  requester (0/1) that issued the held result
- o_busy  output  1  high in any state other than IDLE
- o_err_count  output  CNT_W  saturating count of results delivered with o_error=1

## Operation
- Function per accepted operation:
  - o_error=1 if B[BITS-1]=1 (negative) or B > BITS-1.
  - Otherwise o_error=0 and o_result = (1 << B) | ~A.
  - On error o_result is forced to 0; never X.
- FSM states IDLE, LICZ, WYNIK:
  - IDLE: if any request valid, grant one.
    - Selected requester's ready is high combinationally in IDLE only; the other ready stays low.
    - Operands and grant id are latched; go to LICZ.
    - With no valid request, stay in IDLE.
  - LICZ: drive latched operands through the bit-set unit; register result, error and grant id into output registers; go to WYNIK.
  - WYNIK: o_valid=1. When i_ready=1, the result is consumed: increment o_err_count if o_error=1 (saturate at all-ones), go to IDLE. Otherwise hold all outputs stable.
- Arbitration:
  - Round-robin pointer, reset value 0, points to the preferred requester.
  - Both valid: grant pointer's requester. Single valid: grant it regardless of pointer.
  - Pointer is set to the complement of the granted id on every grant.
- Requesters must hold valid and operands until ready is seen. Dropping valid before grant is legal; the request is not recorded.
- o_req0_ready and o_req1_ready are never high in the same cycle.

## Timing
- Reset (async assert, i_rst_n=0):
  - state=IDLE, pointer=0.
  - o_valid=0, o_result=0, o_error=0, o_grant_id=0, o_busy=0, o_err_count=0.
  - Both readies 0 while reset is asserted.
- Reset mid-operation (LICZ or WYNIK): in-flight operation discarded, no count update; the next grant after release follows pointer=0.
- Latency: grant in cycle N → o_valid=1 from cycle N+2. Minimum issue interval 3 cycles (N, N+1, N+2 with i_ready=1 → next grant N+3).
- o_busy=1 in LICZ and WYNIK.
- Outputs change only on clock edges, except the readies, which are combinational from state, valids and pointer.
- Counter saturates: at 2^CNT_W−1, further error results leave it unchanged.
- Boundaries:
  - B=0 and B=BITS-1 are valid.
  - B=BITS is an error.
  - B=−1 is an error via the sign bit.
  - Very large positive B is an error via the range check.

## Test plan
- Single request, req0 A=0xFFFF_FFFF, B=5, i_ready=1 → grant cycle N, o_valid at N+2, o_result=0x0000_0020, o_error=0, o_grant_id=0, o_err_count=0.
- Both requesters valid continuously after reset (req0 A=0, B=0; req1 A=0, B=31) → grants alternate 0,1,0,1; o_result=0xFFFF_FFFF each time; readies never both high.
- Error cases: B=32, B=0xFFFF_FFFF, B=0x7FFF_FFFF → o_error=1, o_result=0, o_err_count 1→2→3; B=31 with A=0xFFFF_FFFF → o_result=0x8000_0000, o_error=0.
- Backpressure: i_ready=0 for 10 cycles in WYNIK → o_valid, o_result, o_grant_id stable; no new grant; raising i_ready → IDLE next cycle.
- Reset asserted asynchronously during WYNIK with an error result held → all outputs 0 immediately, o_err_count unchanged at 0; after release, req1-only then both valid → first grant of both-valid cycle goes to requester 0 only if the pointer was not moved. Sequence: req1 alone granted, then both valid → requester 0 granted.
- Saturation with CNT_W=2: five error results → o_err_count reads 1,2,3,3,3.
